// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping block.
// Optional alarm states are enabled with CLOCK_ALARM_EN.
package clock_pkg;
    localparam int ONES_W       = 4;
    localparam int SEC_TENS_W   = 3;
    localparam int MIN_TENS_W   = 3;
    localparam int HR_TENS_W    = 2;
    localparam int MAX_ONES     = 9;
    localparam int MAX_SEC_TENS = 5;
    localparam int MAX_MIN_TENS = 5;
    localparam int MAX_HR_TENS  = 2;
    localparam int HR_WRAP_ONES = 3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HR   = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_AL   = 2'd3;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_HR,
        ST_SET_MIN,
        ST_SET_AL_HR,
        ST_SET_AL_MIN
    } state_t;

    function automatic state_t next_state(input state_t s);
        state_t n;
        case (s)
            ST_RUN:       n = ST_SET_HR;
            ST_SET_HR:    n = ST_SET_MIN;
`ifdef CLOCK_ALARM_EN
            ST_SET_MIN:   n = ST_SET_AL_HR;
            ST_SET_AL_HR: n = ST_SET_AL_MIN;
`endif
            default:      n = ST_RUN;
        endcase
        return n;
    endfunction
endpackage

// File: rtl/clock_bcd_field.sv
// One tens/ones BCD digit pair that wraps at MAX_TENS:WRAP_ONES back to 00.
// carry_o flags the wrap in the same cycle so fields can be cascaded.
module clock_bcd_field
    import clock_pkg::*;
#(
    parameter int TENS_W    = 3,
    parameter int MAX_TENS  = 5,
    parameter int WRAP_ONES = 9
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              inc_i,
    input  logic              clear_i,
    output logic [TENS_W-1:0] tens_o,
    output logic [ONES_W-1:0] ones_o,
    output logic              carry_o
);
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [TENS_W-1:0] tens_q, tens_d;
    logic              at_max;

    assign at_max  = (tens_q == TENS_W'(MAX_TENS)) && (ones_q == ONES_W'(WRAP_ONES));
    assign carry_o = inc_i && at_max;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (clear_i) begin
            ones_d = '0;
            tens_d = '0;
        end else if (inc_i) begin
            if (at_max) begin
                ones_d = '0;
                tens_d = '0;
            end else if (ones_q == ONES_W'(MAX_ONES)) begin
                ones_d = '0;
                tens_d = tens_q + TENS_W'(1);
            end else begin
                ones_d = ones_q + ONES_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ones_q <= '0;
            tens_q <= '0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;
endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 Hz prescaler, cascaded BCD hh:mm:ss and set-mode FSM.
// Define CLOCK_ALARM_EN to add the alarm registers, alarm set states and alarm_o.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic [3:0] hr_ones,
    output logic [1:0] hr_tens,
    output logic       tick_o,
    output logic [1:0] sel_o,
    output logic       alarm_o
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             running, edit, sec_clr;
    logic             sec_inc, min_inc, hr_inc;
    logic             sec_carry, min_carry;

    assign tick_o  = (cnt_q == CNT_W'(TICK_DIV - 1));
    // Time only freezes while the clock itself is being edited.
    assign running = (state_q != ST_SET_HR) && (state_q != ST_SET_MIN);
    assign edit    = btn_inc && !btn_mode;
    assign sec_clr = (state_q == ST_SET_MIN) && btn_mode;
    assign sec_inc = running && tick_o;
    assign min_inc = (running && sec_carry) || ((state_q == ST_SET_MIN) && edit);
    assign hr_inc  = (running && min_carry) || ((state_q == ST_SET_HR) && edit);

    always_comb begin
        cnt_d   = tick_o ? '0 : cnt_q + CNT_W'(1);
        state_d = state_q;
        if (sec_clr) cnt_d = '0;
        if (btn_mode) state_d = next_state(state_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_RUN:     sel_o = SEL_NONE;
            ST_SET_HR:  sel_o = SEL_HR;
            ST_SET_MIN: sel_o = SEL_MIN;
            default:    sel_o = SEL_AL;
        endcase
    end

    clock_bcd_field #(.TENS_W(SEC_TENS_W), .MAX_TENS(MAX_SEC_TENS), .WRAP_ONES(MAX_ONES)) u_sec (
        .clk(clk), .rstn(rstn), .inc_i(sec_inc), .clear_i(sec_clr),
        .tens_o(sec_tens), .ones_o(sec_ones), .carry_o(sec_carry)
    );
    clock_bcd_field #(.TENS_W(MIN_TENS_W), .MAX_TENS(MAX_MIN_TENS), .WRAP_ONES(MAX_ONES)) u_min (
        .clk(clk), .rstn(rstn), .inc_i(min_inc), .clear_i(1'b0),
        .tens_o(min_tens), .ones_o(min_ones), .carry_o(min_carry)
    );
    clock_bcd_field #(.TENS_W(HR_TENS_W), .MAX_TENS(MAX_HR_TENS), .WRAP_ONES(HR_WRAP_ONES)) u_hr (
        .clk(clk), .rstn(rstn), .inc_i(hr_inc), .clear_i(1'b0),
        .tens_o(hr_tens), .ones_o(hr_ones), .carry_o()
    );

`ifdef CLOCK_ALARM_EN
    logic [3:0] al_min_ones, al_hr_ones;
    logic [2:0] al_min_tens;
    logic [1:0] al_hr_tens;
    logic       dis_q, dis_d;

    clock_bcd_field #(.TENS_W(MIN_TENS_W), .MAX_TENS(MAX_MIN_TENS), .WRAP_ONES(MAX_ONES)) u_al_min (
        .clk(clk), .rstn(rstn), .inc_i((state_q == ST_SET_AL_MIN) && edit), .clear_i(1'b0),
        .tens_o(al_min_tens), .ones_o(al_min_ones), .carry_o()
    );
    clock_bcd_field #(.TENS_W(HR_TENS_W), .MAX_TENS(MAX_HR_TENS), .WRAP_ONES(HR_WRAP_ONES)) u_al_hr (
        .clk(clk), .rstn(rstn), .inc_i((state_q == ST_SET_AL_HR) && edit), .clear_i(1'b0),
        .tens_o(al_hr_tens), .ones_o(al_hr_ones), .carry_o()
    );

    // Dismiss holds until the minute rolls over, so a match re-arms only on a new minute.
    always_comb begin
        dis_d = dis_q;
        if (sec_carry) dis_d = 1'b0;
        if ((state_q == ST_RUN) && edit) dis_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dis_q <= 1'b0;
        else       dis_q <= dis_d;
    end

    assign alarm_o = (state_q == ST_RUN) && !dis_q &&
                     ({hr_tens, hr_ones, min_tens, min_ones} ==
                      {al_hr_tens, al_hr_ones, al_min_tens, al_min_ones});
`else
    assign alarm_o = 1'b0;
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Randomised + directed bench for clock_time_ctrl against an arithmetic time model.
module tb_clock_time_ctrl;
    localparam int TD = 4;
`ifdef CLOCK_ALARM_EN
    localparam int NST   = 5;
    localparam int EXTRA = 2;
`else
    localparam int NST   = 3;
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_ones, min_ones, hr_ones;
    logic [2:0] sec_tens, min_tens;
    logic [1:0] hr_tens, sel_o;
    logic       tick_o, alarm_o;

    int vectors = 0;
    int miscompares = 0;

    // model state: plain hours/minutes/seconds, state index 0=RUN 1=HR 2=MIN 3=AL_HR 4=AL_MIN
    int m_h, m_m, m_s, m_p, m_st, m_ah, m_am;
    bit m_dis;

    clock_time_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rstn(rstn), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .hr_ones(hr_ones), .hr_tens(hr_tens), .tick_o(tick_o), .sel_o(sel_o), .alarm_o(alarm_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rstn) begin : model
        int  h, m, s, p, st, ah, am, t;
        bit  dis, tick;
        if (!rstn) begin
            m_h <= 0; m_m <= 0; m_s <= 0; m_p <= 0; m_st <= 0;
            m_ah <= 0; m_am <= 0; m_dis <= 1'b0;
        end else begin
            h = m_h; m = m_m; s = m_s; st = m_st; ah = m_ah; am = m_am; dis = m_dis;
            tick = (m_p == TD - 1);
            p = tick ? 0 : m_p + 1;
            if (st != 1 && st != 2 && tick) begin
                if (s == 59) dis = 1'b0;
                t = ((h * 60 + m) * 60 + s + 1) % 86400;
                h = t / 3600; m = (t / 60) % 60; s = t % 60;
            end
            if (!btn_mode && btn_inc) begin
                case (st)
                    0: dis = 1'b1;
                    1: h = (h + 1) % 24;
                    2: m = (m + 1) % 60;
                    3: ah = (ah + 1) % 24;
                    default: am = (am + 1) % 60;
                endcase
            end
            if (btn_mode) begin
                if (st == 2) begin s = 0; p = 0; end
                st = (st + 1) % NST;
            end
            m_h <= h; m_m <= m; m_s <= s; m_p <= p; m_st <= st;
            m_ah <= ah; m_am <= am; m_dis <= dis;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("sec_ones", int'(sec_ones), m_s % 10);
            chk("sec_tens", int'(sec_tens), m_s / 10);
            chk("min_ones", int'(min_ones), m_m % 10);
            chk("min_tens", int'(min_tens), m_m / 10);
            chk("hr_ones",  int'(hr_ones),  m_h % 10);
            chk("hr_tens",  int'(hr_tens),  m_h / 10);
            chk("tick_o",   int'(tick_o),   (m_p == TD - 1) ? 1 : 0);
            chk("sel_o",    int'(sel_o),    (m_st > 3) ? 3 : m_st);
`ifdef CLOCK_ALARM_EN
            chk("alarm_o",  int'(alarm_o),
                (m_st == 0 && m_h == m_ah && m_m == m_am && !m_dis) ? 1 : 0);
`else
            chk("alarm_o",  int'(alarm_o), 0);
`endif
        end
    end

    // one clock with the given button pulses; called at posedge+1
    task automatic cyc(input bit md, input bit inc);
        btn_mode = md;
        btn_inc  = inc;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk({name, "_hr"},  int'(hr_tens) * 10 + int'(hr_ones), h);
        chk({name, "_min"}, int'(min_tens) * 10 + int'(min_ones), m);
        chk({name, "_sec"}, int'(sec_tens) * 10 + int'(sec_ones), s);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_time("reset", 0, 0, 0);
        chk("reset_sel", int'(sel_o), 0);
        chk("reset_tick", int'(tick_o), 0);
        chk("reset_alarm", int'(alarm_o), 0);
        rstn = 1'b1;

        repeat (40) cyc(0, 0);
        chk_time("ten_ticks", 0, 0, 10);

        // preload 23:59 then let seconds run up to 59
        cyc(1, 0);
        repeat (23) cyc(0, 1);
        cyc(1, 0);
        repeat (59) cyc(0, 1);
        cyc(1, 0);
        repeat (EXTRA) cyc(1, 0);
        repeat (236 - EXTRA) cyc(0, 0);
        chk_time("pre_wrap", 23, 59, 59);
        chk("pre_wrap_sel", int'(sel_o), 0);
        repeat (3) cyc(0, 0);
        chk_time("pre_wrap_hold", 23, 59, 59);
        cyc(0, 0);
        chk_time("day_wrap", 0, 0, 0);

        // 61 increments in SET_MIN: wraps within the field, no hour carry
        cyc(1, 0);
        cyc(1, 0);
        repeat (61) cyc(0, 1);
        chk_time("min_61", 0, 1, 0);
        chk("min_61_sel", int'(sel_o), 2);

        // leaving SET_MIN restarts the prescaler
        cyc(1, 0);
        chk("exit_sec", int'(sec_tens) * 10 + int'(sec_ones), 0);
        n = 0;
        while (!tick_o && n < 10) begin
            cyc(0, 0);
            n++;
        end
        chk("tick_gap", n, 3);

        repeat (EXTRA) cyc(1, 0);
        cyc(1, 0);
        chk("in_set_hr", int'(sel_o), 1);
        cyc(1, 1);
        chk("mode_wins_sel", int'(sel_o), 2);
        chk("mode_wins_hr", int'(hr_tens) * 10 + int'(hr_ones), 0);

        // async reset in the middle of an edit
        repeat (2) cyc(0, 1);
        #2 rstn = 1'b0;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst_sel", int'(sel_o), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

`ifdef CLOCK_ALARM_EN
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 1);
        cyc(1, 0);
        repeat (236) cyc(0, 0);
        chk("alarm_pre", int'(alarm_o), 0);
        cyc(0, 0);
        chk_time("alarm_time", 0, 1, 0);
        chk("alarm_hit", int'(alarm_o), 1);
        cyc(0, 1);
        chk("alarm_dismiss", int'(alarm_o), 0);
`endif

        repeat (3000) cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0));
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
